// File: rtl/dp_mem_tester_pkg.sv
// rtl/dp_mem_tester_pkg.sv - shared types and constants for the dual-port memory tester
package dp_mem_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_NADDR = 2'd1;
    localparam logic [1:0] PAT_CONST = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    // Galois form of x^8+x^6+x^5+x^4+1, shifting right
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/dp_pattern_gen.sv
// rtl/dp_pattern_gen.sv - test pattern generator (address, inverted address, constant, LFSR)
module dp_pattern_gen
    import dp_mem_tester_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_seed,
    input  logic              advance,
    input  logic [1:0]        sel,
    input  logic [7:0]        addr_lo,
    input  logic [DATA_W-1:0] const_val,
    output logic [DATA_W-1:0] pattern
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] seed8;

    // LFSR next value: a zero seed would lock up, so it is replaced by 01
    always_comb begin
        seed8  = 8'(load_seed);
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed8 == 8'h00) ? 8'h01 : seed8;
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'h00;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Pattern byte for the current address
    always_comb begin
        pattern = '0;
        case (sel)
            PAT_ADDR:  pattern = DATA_W'(addr_lo);
            PAT_NADDR: pattern = DATA_W'(~addr_lo);
            PAT_CONST: pattern = const_val;
            default:   pattern = DATA_W'(lfsr_q);
        endcase
    end

endmodule

// File: rtl/dp_mem_tester.sv
// rtl/dp_mem_tester.sv - write-then-verify master for one arbiter client port
module dp_mem_tester
    import dp_mem_tester_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic              oe_n,
    output logic              we_n,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;

    logic              gen_load;
    logic              gen_adv;
    logic [DATA_W-1:0] gen_load_seed;
    logic [DATA_W-1:0] pattern;
    logic              last_cycle;
    logic              last_addr;

    dp_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (gen_load),
        .load_seed (gen_load_seed),
        .advance   (gen_adv),
        .sel       (sel_q),
        .addr_lo   (addr_q[7:0]),
        .const_val (seed_q),
        .pattern   (pattern)
    );

    // Sequencer: hold each access ACCESS_CYCLES cycles, walk all addresses twice
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        seed_d        = seed_q;
        err_d         = err_q;
        first_d       = first_q;
        gen_load      = 1'b0;
        gen_adv       = 1'b0;
        gen_load_seed = seed_q;
        last_cycle    = (cnt_q == CNT_W'(ACCESS_CYCLES - 1));
        last_addr     = (addr_q == {ADDR_W{1'b1}});

        if (abort) begin
            // error results of the cancelled run stay visible
            state_d = ST_IDLE;
            addr_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sel_d         = pattern_sel;
                        seed_d        = seed;
                        err_d         = '0;
                        first_d       = '0;
                        addr_d        = '0;
                        cnt_d         = '0;
                        gen_load      = 1'b1;
                        gen_load_seed = seed;
                        state_d       = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (last_cycle) begin
                        cnt_d = '0;
                        if (last_addr) begin
                            // replay the same sequence for the read pass
                            addr_d   = '0;
                            gen_load = 1'b1;
                            state_d  = ST_READ;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            gen_adv = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_READ: begin
                    if (last_cycle) begin
                        cnt_d = '0;
                        if (dout != pattern) begin
                            err_d = err_q + (ADDR_W + 1)'(1);
                            if (err_q == '0) begin
                                first_d = addr_q;
                            end
                        end
                        if (last_addr) begin
                            addr_d  = '0;
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            gen_adv = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= PAT_ADDR;
            seed_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    // Port and status outputs decode straight from state so reset clears them at once
    always_comb begin
        busy           = (state_q == ST_WRITE) || (state_q == ST_READ);
        a              = busy ? addr_q : '0;
        din            = (state_q == ST_WRITE) ? pattern : '0;
        we_n           = (state_q != ST_WRITE);
        oe_n           = (state_q != ST_READ);
        done           = (state_q == ST_DONE);
        pass           = done && (err_q == '0);
        err_count      = err_q;
        first_err_addr = first_q;
    end

endmodule

// File: tb/tb_dp_mem_tester.sv
// tb/tb_dp_mem_tester.sv - testbench for dp_mem_tester with arbiter and SRAM model
module tb_dp_mem_tester;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #18 clk = ~clk;

    logic       rst_n;
    logic       start0, abort0, start1, abort1;
    logic [1:0] sel0, sel1;
    logic [7:0] seed0, seed1;
    logic [9:0] a0, a1;
    logic [7:0] din0, din1, dout0, dout1;
    logic       oe0, we0, oe1, we1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [10:0] err0, err1;
    logic [9:0] fe0, fe1;

    dp_mem_tester u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .pattern_sel(sel0), .seed(seed0), .a(a0), .din(din0), .dout(dout0),
        .oe_n(oe0), .we_n(we0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_addr(fe0)
    );

    dp_mem_tester u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .pattern_sel(sel1), .seed(seed1), .a(a1), .din(din1), .dout(dout1),
        .oe_n(oe1), .we_n(we1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_addr(fe1)
    );

    // Arbiter + SRAM model: 2-cycle slot per port every 4 cycles, read data registered at slot end
    logic [7:0] mem [DEPTH];
    logic [1:0] phase = 2'd0;
    bit         dual  = 1'b0;
    bit         stuck = 1'b0;
    logic [9:0] phys0, phys1;

    assign phys0 = dual ? {1'b0, a0[8:0]} : a0;
    assign phys1 = {1'b1, a1[8:0]};

    always @(posedge clk) begin
        phase <= phase + 2'd1;
        if (phase == 2'd1) begin
            if (!we0) mem[phys0] <= (stuck && phys0 == 10'h200) ? (din0 & 8'hF7) : din0;
            if (!oe0) dout0 <= mem[phys0];
        end
        if (phase == 2'd3) begin
            if (!we1) mem[phys1] <= (stuck && phys1 == 10'h200) ? (din1 & 8'hF7) : din1;
            if (!oe1) dout1 <= mem[phys1];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int err;
        int first;
        bit pass;
    } res_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] seed;
        bit         stuck;
        bit         dual;
        int         exp_err;
        int         exp_first;
        bit         exp_pass;
    } vec_t;

    wr_t  wq[$];
    res_t rq[$];

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ ({8{l[0]}} & 8'hB8);
    endfunction

    // Expected write stream for one run
    task automatic push_writes(input logic [1:0] s, input logic [7:0] sd);
        logic [7:0] l;
        logic [9:0] ai;
        wr_t        w;
        wq.delete();
        l = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < DEPTH; i++) begin
            ai = 10'(i);
            w.addr = ai;
            case (s)
                2'd0:    w.data = ai[7:0];
                2'd1:    w.data = ~ai[7:0];
                2'd2:    w.data = sd;
                default: w.data = l;
            endcase
            wq.push_back(w);
            l = lfsr_step(l);
        end
    endtask

    // Write monitor on port 0: each new write access is popped and compared
    logic       prev_we = 1'b1;
    logic [9:0] prev_a  = '0;
    logic [7:0] wcap [4];
    int         ncap = 0;

    always @(posedge clk) begin
        wr_t e;
        if (!we0 && (prev_we || a0 != prev_a)) begin
            if (ncap < 4) begin
                wcap[ncap] = din0;
                ncap++;
            end
            if (wq.size() == 0) begin
                check("wr_unexpected", 32'(wq.size()), 32'd1);
            end else begin
                e = wq.pop_front();
                check("wr_addr", 32'(a0), 32'(e.addr));
                check("wr_data", 32'(din0), 32'(e.data));
            end
        end
        prev_we = we0;
        prev_a  = a0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input logic [1:0] s, input logic [7:0] sd, input bit both);
        sel0  = s;
        seed0 = sd;
        push_writes(s, sd);
        ncap   = 0;
        start0 = 1'b1;
        start1 = both;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 13000 && !(done0 && (!dual || done1)); c++) step();
        check("done_reached", 32'(done0), 32'd1);
    endtask

    task automatic check_result();
        res_t r;
        r = rq.pop_front();
        check("err_count", 32'(err0), 32'(r.err));
        check("first_err_addr", 32'(fe0), 32'(r.first));
        check("pass", 32'(pass0), 32'(r.pass));
        check("writes_all_seen", 32'(wq.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a"}, 32'(a0), 32'd0);
        check({tag, "_din"}, 32'(din0), 32'd0);
        check({tag, "_we_n"}, 32'(we0), 32'd1);
        check({tag, "_oe_n"}, 32'(oe0), 32'd1);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_done"}, 32'(done0), 32'd0);
        check({tag, "_pass"}, 32'(pass0), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{sel: 2'd0, seed: 8'h00, stuck: 1'b0, dual: 1'b0, exp_err: 0, exp_first: 0, exp_pass: 1'b1};
        vecs[1] = '{sel: 2'd3, seed: 8'h00, stuck: 1'b0, dual: 1'b0, exp_err: 0, exp_first: 0, exp_pass: 1'b1};
        vecs[2] = '{sel: 2'd1, seed: 8'h5A, stuck: 1'b0, dual: 1'b1, exp_err: 0, exp_first: 0, exp_pass: 1'b1};
        vecs[3] = '{sel: 2'd2, seed: 8'hFF, stuck: 1'b1, dual: 1'b0, exp_err: 1, exp_first: 32'h200, exp_pass: 1'b0};

        rst_n = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        sel0 = 2'd0; seed0 = 8'h00; sel1 = 2'd0; seed1 = 8'h00;
        step();
        step();
        check_idle("reset");
        check("reset_err", 32'(err0), 32'd0);
        check("reset_first", 32'(fe0), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            stuck = vecs[i].stuck;
            dual  = vecs[i].dual;
            rq.push_back('{err: vecs[i].exp_err, first: vecs[i].exp_first, pass: vecs[i].exp_pass});
            run_start(vecs[i].sel, vecs[i].seed, vecs[i].dual);
            wait_done();
            check_result();
            if (vecs[i].dual) begin
                check("dual_pass1", 32'(pass1), 32'd1);
                check("dual_err1", 32'(err1), 32'd0);
                check("dual_first1", 32'(fe1), 32'd0);
                check("dual_busy1", 32'(busy1), 32'd0);
            end
            if (i == 0) check("sram_1a5", 32'(mem[10'h1A5]), 32'hA5);
            step();
        end
        dual  = 1'b0;
        stuck = 1'b0;

        // LFSR with zero seed: first written bytes, then abort during write pass
        run_start(2'd3, 8'h00, 1'b0);
        for (int c = 0; c < 30; c++) step();
        check("lfsr_w0", 32'(wcap[0]), 32'h01);
        check("lfsr_w1", 32'(wcap[1]), 32'hB8);
        check("lfsr_w2", 32'(wcap[2]), 32'h5C);
        check("lfsr_w3", 32'(wcap[3]), 32'h2E);
        abort0 = 1'b1;
        start0 = 1'b1;
        step();
        abort0 = 1'b0;
        start0 = 1'b0;
        check_idle("abort_wr");

        // Abort mid-read after a detected error: results hold, next run restarts them
        stuck = 1'b1;
        run_start(2'd2, 8'hFF, 1'b0);
        for (int c = 0; c < 10000; c++) step();
        check("abort_in_read", 32'(oe0), 32'd0);
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check_idle("abort_rd");
        check("abort_err_hold", 32'(err0), 32'd1);
        check("abort_first_hold", 32'(fe0), 32'h200);
        stuck = 1'b0;
        rq.push_back('{err: 0, first: 0, pass: 1'b1});
        run_start(2'd2, 8'hFF, 1'b0);
        wait_done();
        check_result();
        step();

        // start while busy is ignored; async reset mid-read
        run_start(2'd0, 8'h00, 1'b0);
        for (int c = 0; c < 99; c++) step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 0; c < 100; c++) step();
        check("busy_start_ignored_a", 32'(a0), 32'd33);
        check("busy_still", 32'(busy0), 32'd1);
        for (int c = 0; c < 6800; c++) step();
        check("rst_in_read", 32'(oe0), 32'd0);
        #5;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_err", 32'(err0), 32'd0);
        check("async_rst_first", 32'(fe0), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_mem_tester.md
Name: dp_mem_tester

Overview:
- Self-checking master for one client port of the 1K x 8 dual-port SRAM arbiter.
- On start, fills every address with a selectable pattern (write pass), then reads every address back and compares (read pass), reporting pass/fail, error count and first failing address.
- Sits beside the arbiter in the memory test build; two instances can exercise both ports concurrently.

Parameters:
- ADDR_W, 10, address width; depth = 2**ADDR_W.
- DATA_W, 8, data width.
- ACCESS_CYCLES, 6, cycles each access is held on the port; must be >= 6 to guarantee a full arbiter slot completes before read sampling.

Ports:
- clk  in  1  system clock (28 MHz)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin test; sampled only in IDLE or DONE
- abort  in  1  cancel running test, return to IDLE
- pattern_sel  in  2  0=addr[7:0], 1=~addr[7:0], 2=constant seed, 3=LFSR
- seed  in  DATA_W  constant value / LFSR seed; latched at start
- a  out  ADDR_W  address to arbiter port
- din  out  DATA_W  write data to arbiter port
- dout  in  DATA_W  read data from arbiter port
- oe_n  out  1  port output enable, low during read pass
- we_n  out  1  port write enable, low during write pass
- busy  out  1  high in WRITE or READ
- done  out  1  high in DONE until next start/abort
- pass  out  1  valid while done: err_count == 0
- err_count  out  ADDR_W+1  mismatches in last run, 0..1024, no saturation needed
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none

Behaviour:
- Reset, asynchronous: state IDLE; a=0, din=0, oe_n=1, we_n=1, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, cycle counter=0, LFSR=0.
- IDLE, or DONE with start=1: latch pattern_sel and seed; clear err_count and first_err_addr; addr=0; load generator; go to WRITE next cycle.
- WRITE: a=addr, din=pattern(addr), we_n=0, oe_n=1, all held constant for ACCESS_CYCLES cycles.
  - On the last cycle: advance addr and generator.
  - At addr = depth-1: wrap addr to 0, reload generator from latched seed, go to READ.
  - we_n stays low across address changes. The arbiter samples address and we_n in its slot, so changes at cycle boundaries are allowed.
- READ: a=addr, oe_n=0, we_n=1, din=0, held ACCESS_CYCLES cycles.
  - Compare dout with expected pattern on the clock edge ending the last cycle.
  - Mismatch: err_count+1; if err_count was 0, first_err_addr=addr.
  - Then advance as in WRITE. After depth-1, go to DONE.
- Why 6 cycles: the arbiter serves each port in a 2-cycle slot every 4 cycles and registers read data at the end of the slot. Any 5-cycle window contains a full slot; the 6th edge samples the updated register.
- DONE: done=1, pass=(err_count==0), a/oe_n/we_n at idle values (oe_n=1, we_n=1).
- start while busy: ignored.
- abort: any state goes to IDLE next cycle; outputs return to reset idle values except err_count and first_err_addr, which hold; done=0. abort has priority over start in the same cycle.
- LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1. A seed of 0 is replaced by 8'h01. It advances once per address, so the write and read sequences are identical.
- Reset mid-pass: immediate idle; the memory content is undefined and is not checked.

Decomposition:
- Package dp_mem_tester_pkg: state encoding (IDLE, WRITE, READ, DONE), pattern_sel constants (PAT_ADDR, PAT_NADDR, PAT_CONST, PAT_LFSR), LFSR tap mask 8'hB8.
- Sub-module dp_pattern_gen: holds the LFSR and produces the pattern byte from sel, addr and seed. Inputs load and advance; output combinational pattern.

Test Plan:
- Arbiter plus SRAM model; start with pattern_sel=0 -> after 2*1024*6+2 cycles done=1, pass=1, err_count=0, first_err_addr=0; SRAM[0x1A5]=8'hA5.
- pattern_sel=3, seed=0 -> written sequence starts 01, B8, 5C, 2E; read pass matches; pass=1.
- SRAM model with bit 3 stuck-0 at address 0x200, pattern_sel=2, seed=8'hFF -> err_count=1, first_err_addr=0x200, pass=0.
- Two instances on both ports concurrently, pattern 0 and pattern 1 -> both pass=1 when each targets a separate half of the memory, split by a[9] via a wrapper.
- abort at cycle 3000 -> IDLE next cycle, busy=0, done=0, we_n=1; a following start completes a fresh run with err_count restarted at 0.
- rst_n low mid-READ -> all outputs at reset values within the same cycle, asynchronously; start ignored while busy (pulse at cycle 100 does not restart the run).
